cmos_capture: RTL

- Capture front-end for the 8-bit DVP camera bus: cmos_data, cmos_href, cmos_vsyn, all in the cmos_pclk domain.
- Pairs bytes into RGB565 pixels (high byte first) and tracks pixel and line position.
- Discards settling frames after reset and flags malformed frames.
- Feeds the downstream write FIFO / SDRAM frame writer as a valid-only pixel stream with no backpressure.

---
 rtl/cmos_capture.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmos_capture.sv
`timescale 1ns/1ps
// cmos_capture: DVP byte bus -> RGB565 pixel stream with frame skip and
// frame error tracking.
// Ports: cmos_pclk/rst_n clock and async reset; cmos_data/href/vsyn camera
// bus; pix_* pixel stream with position; frame_done/cnt/err frame status.
module cmos_capture #(
  parameter int H_ACTIVE   = 512,
  parameter int V_ACTIVE   = 8,
  parameter int FRAME_SKIP = 2
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic [7:0]  cmos_data,
  input  logic        cmos_href,
  input  logic        cmos_vsyn,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        frame_err
);

  localparam logic [15:0] HA = 16'(H_ACTIVE);
  localparam logic [15:0] VA = 16'(V_ACTIVE);
  localparam logic [15:0] SK = 16'(FRAME_SKIP);

  typedef enum logic [1:0] {
    IDLE, SKIP, ARMED, CAPT
  } state_e;

  function automatic logic [15:0] inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [7:0]  data_d1_q;
  logic        href_d1_q, href_d2_q;
  logic        vsyn_d1_q, vsyn_d2_q;

  state_e      state_q, state_d;
  logic [15:0] skip_q, skip_d;
  logic        phase_q, phase_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        got_q, got_d;
  logic        err_q, err_d;

  logic        s1_vld_q, s1_vld_d;
  logic        s1_sof_q, s1_sof_d;
  logic        s1_eol_q, s1_eol_d;
  logic [15:0] s1_dat_q, s1_dat_d;
  logic [15:0] s1_x_q, s1_x_d;
  logic [15:0] s1_y_q, s1_y_d;
  logic        s1_done_q, s1_done_d;
  logic        s1_ferr_q, s1_ferr_d;

  logic vs_rise, vs_fall, href_fall;
  logic accept, trunc;
  logic [15:0] y_fin;

  assign vs_rise   = vsyn_d1_q & ~vsyn_d2_q;
  assign vs_fall   = ~vsyn_d1_q & vsyn_d2_q;
  assign href_fall = ~href_d1_q & href_d2_q;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      data_d1_q <= '0;
      href_d1_q <= 1'b0;
      href_d2_q <= 1'b0;
      vsyn_d1_q <= 1'b0;
      vsyn_d2_q <= 1'b0;
    end else begin
      data_d1_q <= cmos_data;
      href_d1_q <= cmos_href;
      href_d2_q <= href_d1_q;
      vsyn_d1_q <= cmos_vsyn;
      vsyn_d2_q <= vsyn_d1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    phase_d   = phase_q;
    hi_d      = hi_q;
    x_d       = x_q;
    y_d       = y_q;
    got_d     = got_q;
    err_d     = err_q;
    s1_vld_d  = 1'b0;
    s1_sof_d  = 1'b0;
    s1_eol_d  = 1'b0;
    s1_done_d = 1'b0;
    s1_dat_d  = s1_dat_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_ferr_d = s1_ferr_q;
    accept    = 1'b0;
    trunc     = 1'b0;
    y_fin     = y_q;

    unique case (state_q)
      IDLE: begin
        if (vs_rise) begin
          skip_d  = '0;
          state_d = (SK == 16'd0) ? ARMED : SKIP;
        end
      end
      SKIP: begin
        if (vs_rise) begin
          skip_d = skip_q + 16'd1;
          if (skip_q + 16'd1 == SK) state_d = ARMED;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_d = CAPT;
          x_d     = '0;
          y_d     = '0;
          err_d   = 1'b0;
          phase_d = 1'b0;
          got_d   = 1'b0;
        end
      end
      CAPT: begin
        accept = href_d1_q & ~vsyn_d1_q;
        if (accept) begin
          got_d   = 1'b1;
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_d1_q;
          end else begin
            x_d = inc16(x_q);
            if (x_q < HA && y_q < VA) begin
              s1_vld_d = 1'b1;
              s1_dat_d = {hi_q, data_d1_q};
              s1_x_d   = x_q;
              s1_y_d   = y_q;
              s1_sof_d = (x_q == 16'd0) && (y_q == 16'd0);
              s1_eol_d = (x_q == HA - 16'd1);
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (href_fall) begin
          phase_d = 1'b0;
          x_d     = '0;
          got_d   = 1'b0;
          if (got_q) begin
            y_d = inc16(y_q);
            if (x_q != HA || phase_q) err_d = 1'b1;
          end
        end
        // A frame sync arriving while a line is still open cuts it short.
        trunc = vs_rise & got_q & ~href_fall;
        y_fin = trunc ? inc16(y_q) : y_d;
        if (vs_rise) begin
          s1_done_d = 1'b1;
          s1_ferr_d = err_d | trunc | (y_fin != VA);
          phase_d   = 1'b0;
          got_d     = 1'b0;
          state_d   = ARMED;
        end
      end
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      skip_q    <= '0;
      phase_q   <= 1'b0;
      hi_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      got_q     <= 1'b0;
      err_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_sof_q  <= 1'b0;
      s1_eol_q  <= 1'b0;
      s1_dat_q  <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_done_q <= 1'b0;
      s1_ferr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      x_q       <= x_d;
      y_q       <= y_d;
      got_q     <= got_d;
      err_q     <= err_d;
      s1_vld_q  <= s1_vld_d;
      s1_sof_q  <= s1_sof_d;
      s1_eol_q  <= s1_eol_d;
      s1_dat_q  <= s1_dat_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_done_q <= s1_done_d;
      s1_ferr_q <= s1_ferr_d;
    end
  end

  // Output stage keeps pixels and the frame strobe in stream order.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid  <= 1'b0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      frame_err  <= 1'b0;
    end else begin
      pix_valid  <= s1_vld_q;
      pix_sof    <= s1_sof_q;
      pix_eol    <= s1_eol_q;
      pix_data   <= s1_dat_q;
      pix_x      <= s1_x_q;
      pix_y      <= s1_y_q;
      frame_done <= s1_done_q;
      if (s1_done_q) begin
        frame_cnt <= frame_cnt + 16'd1;
        frame_err <= s1_ferr_q;
      end
    end
  end

endmodule
